// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter: RAM status encoding,
// data word, and arbiter FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    localparam logic [1:0] FAIR_LIMIT = 2'd3;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an icache and a dcache.
// The dcache has priority; with ARB_FAIR_EN defined, the icache is
// granted after three consecutive dcache completions that starved it.
module mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       iREN,
    input  word_t      iaddr,
    output logic       iwait,
    output word_t      iload,
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output logic       dwait,
    output word_t      dload,
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  logic [1:0] ramstate
);

    arb_state_t state, next_state;
    ramstate_t  rs;
    logic       dreq;
    logic       dcomplete;
    logic       icomplete;
    logic       i_turn;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

`ifdef ARB_FAIR_EN
    logic [1:0] fair_cnt;

    // Count dcache completions that left the icache waiting; icache service clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fair_cnt <= 2'd0;
        end else if (icomplete) begin
            fair_cnt <= 2'd0;
        end else if (dcomplete) begin
            if (!iREN)
                fair_cnt <= 2'd0;
            else if (fair_cnt != FAIR_LIMIT)
                fair_cnt <= fair_cnt + 2'd1;
        end
    end

    assign i_turn = (fair_cnt == FAIR_LIMIT) && iREN;
`else
    assign i_turn = 1'b0;
`endif

    // Arbiter state register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state selection and RAM/cache side outputs for the current grant.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        dcomplete  = 1'b0;
        icomplete  = 1'b0;

        case (state)
            IDLE: begin
                if (dreq && !i_turn)
                    next_state = DGRANT;
                else if (iREN)
                    next_state = IGRANT;
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (rs == ACCESS) begin
                    dwait      = 1'b0;
                    dload      = dWEN ? '0 : ramload;
                    dcomplete  = 1'b1;
                    next_state = IDLE;
                end else if (rs == ERROR) begin
                    next_state = IDLE;
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (rs == ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    icomplete  = 1'b1;
                    next_state = IDLE;
                end else if (rs == ERROR) begin
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run
// against a reference model. Honours ARB_FAIR_EN when defined.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       iREN;
    word_t      iaddr;
    logic       iwait;
    word_t      iload;
    logic       dREN;
    logic       dWEN;
    word_t      daddr;
    word_t      dstore;
    logic       dwait;
    word_t      dload;
    logic       ramREN;
    logic       ramWEN;
    word_t      ramaddr;
    word_t      ramstore;
    word_t      ramload;
    logic [1:0] ramstate;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
    endtask

    // Leaves the DUT in IDLE at the start of a cycle with quiet inputs.
    task automatic do_reset();
        step();
        RST = 1'b1;
        idle_inputs();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        step();
        RST      = 1'b1;
        iREN     = 1'b1;
        dREN     = 1'b1;
        dWEN     = 1'b1;
        daddr    = 32'hAAAA_0000;
        dstore   = 32'h1111_2222;
        ramstate = ACCESS;
        ramload  = 32'hFFFF_FFFF;
        step();
        @(negedge CLK);
        n_checks++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100)
            $display("FAIL reset_ctrl: got %b need 1100", {iwait, dwait, ramREN, ramWEN});
        else n_pass++;
        n_checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'd0)
            $display("FAIL reset_data: got %h need 0", {ramaddr, ramstore, iload, dload});
        else n_pass++;
        RST = 1'b0;
        idle_inputs();
    endtask

    task automatic test_icache_read();
        do_reset();
        iREN  = 1'b1;
        iaddr = 32'h40;
        @(negedge CLK);
        n_checks++;
        if ({iwait, ramREN} !== 2'b10)
            $display("FAIL iread_req_cycle: got %b need 10", {iwait, ramREN});
        else n_pass++;
        step();
        ramstate = ACCESS;
        ramload  = 32'hDEAD_BEEF;
        @(negedge CLK);
        n_checks++;
        if ({iwait, dwait, ramREN, ramWEN, ramaddr} !== {4'b0110, 32'h40})
            $display("FAIL iread_grant: got %b %h need 0110 00000040",
                     {iwait, dwait, ramREN, ramWEN}, ramaddr);
        else n_pass++;
        n_checks++;
        if (iload !== 32'hDEAD_BEEF)
            $display("FAIL iread_data: got %h need deadbeef", iload);
        else n_pass++;
        step();
        iREN     = 1'b0;
        ramstate = FREE;
        @(negedge CLK);
        n_checks++;
        if ({iwait, ramREN, iload} !== {2'b10, 32'h0})
            $display("FAIL iread_after: got %b %b %h need 1 0 0", iwait, ramREN, iload);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        iREN     = 1'b1;
        iaddr    = 32'h44;
        dWEN     = 1'b1;
        daddr    = 32'h80;
        dstore   = 32'h1234_5678;
        ramstate = ACCESS;
        ramload  = 32'hCAFE_F00D;
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN} !== 2'b00)
            $display("FAIL simul_idle: got %b need 00", {ramREN, ramWEN});
        else n_pass++;
        step();
        @(negedge CLK);
        n_checks++;
        if ({ramWEN, ramREN, dwait, iwait, ramaddr, ramstore} !== {4'b1001, 32'h80, 32'h1234_5678})
            $display("FAIL simul_dgrant: got %b %h %h need 1001 00000080 12345678",
                     {ramWEN, ramREN, dwait, iwait}, ramaddr, ramstore);
        else n_pass++;
        step();
        dWEN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN, iwait} !== 3'b001)
            $display("FAIL simul_between: got %b need 001", {ramREN, ramWEN, iwait});
        else n_pass++;
        step();
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN, iwait, ramaddr, ramstore, iload} !== {3'b100, 32'h44, 32'h0, 32'hCAFE_F00D})
            $display("FAIL simul_igrant: got %b %h %h %h need 100 00000044 0 cafef00d",
                     {ramREN, ramWEN, iwait}, ramaddr, ramstore, iload);
        else n_pass++;
        step();
        idle_inputs();
    endtask

    task automatic test_busy_wait();
        int high_cycles;
        do_reset();
        high_cycles = 0;
        dREN     = 1'b1;
        daddr    = 32'h100;
        ramload  = 32'h55AA_55AA;
        ramstate = BUSY;
        @(negedge CLK);
        if (dwait === 1'b1) high_cycles++;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge CLK);
            if (dwait === 1'b1 && ramREN === 1'b1 && ramaddr === 32'h100) high_cycles++;
        end
        n_checks++;
        if (high_cycles != 4)
            $display("FAIL busy_high_cycles: got %0d need 4", high_cycles);
        else n_pass++;
        step();
        ramstate = ACCESS;
        @(negedge CLK);
        n_checks++;
        if ({dwait, dload} !== {1'b0, 32'h55AA_55AA})
            $display("FAIL busy_complete: got %b %h need 0 55aa55aa", dwait, dload);
        else n_pass++;
        step();
        idle_inputs();
    endtask

    task automatic test_error_retry();
        do_reset();
        iREN  = 1'b1;
        iaddr = 32'h200;
        @(negedge CLK);
        step();
        ramstate = ERROR;
        ramload  = 32'h7777_7777;
        @(negedge CLK);
        n_checks++;
        if ({iwait, ramREN, iload} !== {2'b11, 32'h0})
            $display("FAIL error_grant: got %b %b %h need 1 1 0", iwait, ramREN, iload);
        else n_pass++;
        step();
        ramstate = ACCESS;
        @(negedge CLK);
        n_checks++;
        if ({iwait, ramREN} !== 2'b10)
            $display("FAIL error_back_idle: got %b need 10", {iwait, ramREN});
        else n_pass++;
        step();
        ramload = 32'h0BAD_F00D;
        @(negedge CLK);
        n_checks++;
        if ({iwait, ramREN, iload} !== {2'b01, 32'h0BAD_F00D})
            $display("FAIL error_retry: got %b %b %h need 0 1 0badf00d", iwait, ramREN, iload);
        else n_pass++;
        step();
        idle_inputs();
    endtask

    task automatic test_drop_request();
        do_reset();
        dREN  = 1'b1;
        daddr = 32'h180;
        @(negedge CLK);
        step();
        dREN     = 1'b0;
        ramstate = ACCESS;
        ramload  = 32'h1357_9BDF;
        @(negedge CLK);
        n_checks++;
        if ({dwait, dload} !== {1'b1, 32'h0})
            $display("FAIL drop_no_complete: got %b %h need 1 0", dwait, dload);
        else n_pass++;
        step();
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN, ramaddr} !== {2'b00, 32'h0})
            $display("FAIL drop_idle: got %b %h need 00 0", {ramREN, ramWEN}, ramaddr);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        dWEN     = 1'b1;
        daddr    = 32'h300;
        dstore   = 32'hFFFF_0000;
        ramstate = BUSY;
        @(negedge CLK);
        step();
        @(negedge CLK);
        n_checks++;
        if (ramWEN !== 1'b1)
            $display("FAIL rstmid_pre: got %b need 1", ramWEN);
        else n_pass++;
        RST = 1'b1;
        step();
        RST      = 1'b0;
        ramstate = ACCESS;
        @(negedge CLK);
        n_checks++;
        if ({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload} !== {4'b1100, 128'd0})
            $display("FAIL rstmid_after: got %b %h %h need 1100 0 0",
                     {iwait, dwait, ramREN, ramWEN}, ramaddr, ramstore);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_fairness();
        int seen;
        bit got_i;
        bit exp_i;
        do_reset();
        seen     = 0;
        iREN     = 1'b1;
        dREN     = 1'b1;
        iaddr    = 32'h10;
        daddr    = 32'h20;
        ramstate = ACCESS;
        for (int cyc = 0; cyc < 48 && seen < 16; cyc++) begin
            ramload = $urandom;
            @(negedge CLK);
            if (iwait === 1'b0 || dwait === 1'b0) begin
                got_i = (iwait === 1'b0);
                exp_i = FAIR && ((seen % 4) == 3);
                n_checks++;
                if (got_i !== exp_i)
                    $display("FAIL fair_order[%0d]: got %s need %s", seen,
                             got_i ? "I" : "D", exp_i ? "I" : "D");
                else n_pass++;
                seen++;
            end
            step();
        end
        n_checks++;
        if (seen != 16)
            $display("FAIL fair_count: got %0d completions need 16", seen);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        int g;
        int cnt;
        bit dreq;
        bit dload_dc;
        logic [99:0] exp_vec;
        word_t e_dload;
        do_reset();
        g   = 0;
        cnt = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            iREN     = ($urandom_range(0, 3) != 0);
            dREN     = $urandom_range(0, 1);
            dWEN     = ($urandom_range(0, 3) == 0);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            dreq     = dREN | dWEN;
            dload_dc = 1'b0;
            e_dload  = '0;

            // Expected outputs: {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload}
            if (g == 1) begin
                exp_vec = {2'b11, dREN & ~dWEN, dWEN, daddr, dstore, 32'h0};
                if (dreq && ramstate == ACCESS) begin
                    exp_vec[98] = 1'b0;
                    if (dWEN) dload_dc = 1'b1;
                    else e_dload = ramload;
                end
            end else if (g == 2) begin
                exp_vec = {4'b1110, iaddr, 32'h0, 32'h0};
                if (iREN && ramstate == ACCESS) begin
                    exp_vec[99]   = 1'b0;
                    exp_vec[31:0] = ramload;
                end
            end else begin
                exp_vec = {4'b1100, 96'd0};
            end

            @(negedge CLK);
            n_checks++;
            if ({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload} !== exp_vec)
                $display("FAIL random_out[%0d]: got %h need %h", cyc,
                         {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload}, exp_vec);
            else n_pass++;
            if (!dload_dc) begin
                n_checks++;
                if (dload !== e_dload)
                    $display("FAIL random_dload[%0d]: got %h need %h", cyc, dload, e_dload);
                else n_pass++;
            end

            // Where the arbiter stands after this edge.
            if (g == 0) begin
                if (dreq && !(FAIR && cnt == 3 && iREN)) g = 1;
                else if (iREN) g = 2;
            end else if (g == 1) begin
                if (!dreq) g = 0;
                else if (ramstate == ACCESS) begin
                    cnt = iREN ? ((cnt < 3) ? cnt + 1 : 3) : 0;
                    g = 0;
                end else if (ramstate == ERROR) g = 0;
            end else begin
                if (!iREN) g = 0;
                else if (ramstate == ACCESS) begin
                    cnt = 0;
                    g = 0;
                end else if (ramstate == ERROR) g = 0;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_icache_read();
        test_simultaneous();
        test_busy_wait();
        test_error_retry();
        test_drop_request();
        test_reset_mid_grant();
        test_fairness();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
